// File: rtl/fifo_route_rx.sv
// Receive-side demultiplexer: splits one header/payload byte stream back into two
// client FIFOs, keeping each packet unbroken and stalling through a 1-entry hold.
module fifo_route_rx #(
    parameter int              DWIDTH  = 8,
    parameter logic [DWIDTH-1:0] SELMASK = 8'h80,
    parameter logic [DWIDTH-1:0] CNTMASK = 8'h70
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              fifo_rdempty,
    output logic              fifo_rden,
    input  logic [DWIDTH-1:0] fifo_rddata,
    input  logic              c1_wrfull,
    output logic              c1_wren,
    output logic [DWIDTH-1:0] c1_wrdata,
    input  logic              c2_wrfull,
    output logic              c2_wren,
    output logic [DWIDTH-1:0] c2_wrdata,
    output logic              cnt_err,
    output logic              busy
);

    function automatic int lsb_of(input logic [DWIDTH-1:0] m);
        int r;
        r = 0;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    localparam int CNT_LSB = lsb_of(CNTMASK);

    typedef enum logic {S_HDR = 1'b0, S_PAY = 1'b1} state_t;

    state_t            state_q;
    logic [3:0]        dcnt_q;
    logic              dest_c1_q;
    logic              rd_pend_q;
    logic              hold_vld_q;
    logic              hold_c1_q;
    logic [DWIDTH-1:0] hold_data_q;
    logic              cnt_err_q;
    // Keeps the read strobe low until the first edge after reset release.
    logic              run_q;

    logic [2:0] code;
    logic [3:0] code_cnt;
    logic       hdr_c1;
    logic       tgt_c1;
    logic       tgt_full;
    logic       arr_wr;
    logic       hold_dst_full;
    logic       drain;

    assign code   = fifo_rddata[CNT_LSB +: 3];
    assign hdr_c1 = (fifo_rddata & SELMASK) == SELMASK;

    always_comb begin
        code_cnt = 4'd0;
        case (code)
            3'd1:    code_cnt = 4'd1;
            3'd2:    code_cnt = 4'd2;
            3'd3:    code_cnt = 4'd4;
            3'd4:    code_cnt = 4'd8;
            default: code_cnt = 4'd0;
        endcase
    end

    // Headers pick their own destination; payload follows the latched one.
    assign tgt_c1        = (state_q == S_HDR) ? hdr_c1 : dest_c1_q;
    assign tgt_full      = tgt_c1 ? c1_wrfull : c2_wrfull;
    assign arr_wr        = rd_pend_q & ~tgt_full;
    assign hold_dst_full = hold_c1_q ? c1_wrfull : c2_wrfull;
    assign drain         = hold_vld_q & ~hold_dst_full;

    // A held byte means no read was issued, so arrival and drain never coincide.
    assign fifo_rden = run_q & ~fifo_rdempty & ~hold_vld_q & ~(rd_pend_q & tgt_full);
    assign busy      = (state_q == S_PAY) | rd_pend_q | hold_vld_q;
    assign cnt_err   = cnt_err_q;

    always_comb begin
        c1_wren   = 1'b0;
        c1_wrdata = '0;
        c2_wren   = 1'b0;
        c2_wrdata = '0;
        if (arr_wr) begin
            if (tgt_c1) begin
                c1_wren   = 1'b1;
                c1_wrdata = fifo_rddata;
            end else begin
                c2_wren   = 1'b1;
                c2_wrdata = fifo_rddata;
            end
        end else if (drain) begin
            if (hold_c1_q) begin
                c1_wren   = 1'b1;
                c1_wrdata = hold_data_q;
            end else begin
                c2_wren   = 1'b1;
                c2_wrdata = hold_data_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_HDR;
            dcnt_q      <= 4'd0;
            dest_c1_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_c1_q   <= 1'b0;
            hold_data_q <= '0;
            cnt_err_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            rd_pend_q <= fifo_rden;
            cnt_err_q <= 1'b0;
            if (drain) hold_vld_q <= 1'b0;
            if (rd_pend_q) begin
                if (tgt_full) begin
                    hold_vld_q  <= 1'b1;
                    hold_c1_q   <= tgt_c1;
                    hold_data_q <= fifo_rddata;
                end
                case (state_q)
                    S_HDR: begin
                        cnt_err_q <= (code >= 3'd5);
                        dest_c1_q <= hdr_c1;
                        if (code_cnt != 4'd0) begin
                            dcnt_q  <= code_cnt;
                            state_q <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        dcnt_q <= dcnt_q - 4'd1;
                        if (dcnt_q == 4'd1) state_q <= S_HDR;
                    end
                    default: state_q <= S_HDR;
                endcase
            end
        end
    end

endmodule
